// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes, FSM states,
// widths and the RISC-V special-case constants. Build option: MDU_FAST_MUL_EN.
package mdu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    localparam logic [XLEN-1:0] DIV_ZERO_QUOT = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] OVF_DIVIDEND  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] OVF_DIVISOR   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] OVF_REM       = {XLEN{1'b0}};

    // Magnitude of a two's complement value; the most negative value maps to 2^(XLEN-1).
    function automatic logic [XLEN-1:0] mdu_abs(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and report the quotient bit.
module mdu_div_step
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, divisor_i};

    // rem_i < divisor keeps shifted below 2*divisor, so the top bit of diff is a clean borrow flag.
    assign q_o   = ~diff[XLEN];
    assign rem_o = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/mdu_controller.sv
// RV32M multi-cycle multiply/divide sequencer for the EX stage (IDLE/CALC/FIX/DONE).
// Define MDU_FAST_MUL_EN to compute multiplies in a single cycle at accept.
module mdu_controller
    import mdu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      select_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    mdu_state_e        state_q;
    logic [2:0]        op_q;
    logic              sign1_q;
    logic              sign2_q;
    logic              special_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;

    // Accept-side decode of the incoming request.
    logic              in_sgn1;
    logic              in_sgn2;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;
    logic              div_zero;
    logic              div_ovf;
    logic              is_special;
    logic [XLEN-1:0]   special_val;
    logic              use_fast;
    logic [2*XLEN-1:0] fast_prod;

    assign in_sgn1 = data1_i[XLEN-1] & ((select_i == MDU_MULH) | (select_i == MDU_MULHSU) |
                                        (select_i == MDU_DIV)  | (select_i == MDU_REM));
    assign in_sgn2 = data2_i[XLEN-1] & ((select_i == MDU_MULH) |
                                        (select_i == MDU_DIV)  | (select_i == MDU_REM));
    assign abs1 = mdu_abs(data1_i, in_sgn1);
    assign abs2 = mdu_abs(data2_i, in_sgn2);

    assign div_zero   = select_i[2] & (data2_i == '0);
    assign div_ovf    = ((select_i == MDU_DIV) | (select_i == MDU_REM)) &
                        (data1_i == OVF_DIVIDEND) & (data2_i == OVF_DIVISOR);
    assign is_special = div_zero | div_ovf;

    always_comb begin
        special_val = '0;
        if (div_zero) begin
            special_val = select_i[1] ? data1_i : DIV_ZERO_QUOT;
        end else if (div_ovf) begin
            special_val = select_i[1] ? OVF_REM : OVF_DIVIDEND;
        end
    end

`ifdef MDU_FAST_MUL_EN
    assign use_fast  = ~select_i[2];
    assign fast_prod = {{XLEN{1'b0}}, abs1} * {{XLEN{1'b0}}, abs2};
`else
    assign use_fast  = 1'b0;
    assign fast_prod = '0;
`endif

    // Iteration datapath: shift-add multiply and restoring divide share the accumulator.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc_d;
    logic [XLEN-1:0]   div_rem;
    logic              div_q;
    logic [2*XLEN-1:0] div_acc_d;
    logic [2*XLEN-1:0] acc_d;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};

    mdu_div_step u_div_step (
        .rem_i     (acc_q[2*XLEN-1:XLEN]),
        .bit_i     (acc_q[XLEN-1]),
        .divisor_i (opnd_q),
        .rem_o     (div_rem),
        .q_o       (div_q)
    );

    assign div_acc_d = {div_rem, acc_q[XLEN-2:0], div_q};
    assign acc_d     = op_q[2] ? div_acc_d : mul_acc_d;

    // Sign fix-up applied in FIX.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_res_d;

    assign prod_fix = (sign1_q ^ sign2_q) ? (~acc_q + 1'b1) : acc_q;
    assign quot     = acc_q[XLEN-1:0];
    assign rem      = acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_res_d = '0;
        if (special_q) begin
            fix_res_d = acc_q[XLEN-1:0];
        end else begin
            case (op_q)
                MDU_MUL:    fix_res_d = acc_q[XLEN-1:0];
                MDU_MULH,
                MDU_MULHSU: fix_res_d = prod_fix[2*XLEN-1:XLEN];
                MDU_MULHU:  fix_res_d = acc_q[2*XLEN-1:XLEN];
                MDU_DIV:    fix_res_d = (sign1_q ^ sign2_q) ? (~quot + 1'b1) : quot;
                MDU_DIVU:   fix_res_d = quot;
                MDU_REM:    fix_res_d = sign1_q ? (~rem + 1'b1) : rem;
                default:    fix_res_d = rem;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= MDU_MUL;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            special_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        op_q      <= select_i;
                        sign1_q   <= in_sgn1;
                        sign2_q   <= in_sgn2;
                        special_q <= is_special;
                        if (is_special) begin
                            acc_q   <= {{XLEN{1'b0}}, special_val};
                            state_q <= FIX;
                        end else if (use_fast) begin
                            acc_q   <= fast_prod;
                            state_q <= FIX;
                        end else begin
                            // Divide shifts the dividend out of the low word; multiply shifts the multiplier.
                            acc_q   <= {{XLEN{1'b0}}, select_i[2] ? abs1 : abs2};
                            opnd_q  <= select_i[2] ? abs2 : abs1;
                            cnt_q   <= CNT_W'(XLEN);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_res_d;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = (state_q == DONE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_mdu_controller.sv
// Directed + small randomized bench for mdu_controller with an expected-result queue.
// Latency expectations follow MDU_FAST_MUL_EN when it is defined for the build.
module tb_mdu_controller;
    import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      sel;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int compared   = 0;
    int mismatched = 0;
    logic [XLEN-1:0] exp_q[$];

    always #5 clk = ~clk;

    mdu_controller dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .select_i    (sel),
        .data1_i     (d1),
        .data2_i     (d2),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .busy_o      (busy)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] s, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (s)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: if (b == 0) return 32'hFFFFFFFF;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                  else return 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                  else return 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        if (!s[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!s[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return DIV_LAT;
    endfunction

    // Called at a falling edge; returns at the falling edge right after the accept edge.
    task automatic accept(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        in_valid = 1'b1;
        sel = s;
        d1 = a;
        d2 = b;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        sel = 3'($urandom);
        d1 = $urandom;
        d2 = $urandom;
    endtask

    task automatic run_op(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int hold, input string tag);
        int n;
        logic [31:0] want;
        logic [31:0] held;
        accept(s, a, b, tag);
        exp_q.push_back(exp);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        chk(tag, result, want);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_result"}, result, held);
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
        chk({tag, "_valid_clear"}, 32'(out_valid), 32'd0);
        $display("op %s sel=%0d a=%h b=%h result=%h latency=%0d", tag, s, a, b, want, n);
    endtask

    task automatic abort_test(input bit use_reset, input string tag);
        bit seen;
        accept(MDU_DIVU, 32'd1000, 32'd7, tag);
        repeat (14) @(negedge clk);
        chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
        if (use_reset) rst = 1'b1;
        else flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_no_result"}, 32'(seen), 32'd0);
        $display("abort %s: result suppressed=%0d", tag, !seen);
        run_op(MDU_DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT, 0, {tag, "_divu_after"});
    endtask

    initial begin
        logic [2:0]  rs;
        logic [31:0] ra, rb;
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        sel = '0;
        d1 = '0;
        d2 = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(MDU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, 0, "mul_7x-3");
        run_op(MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 0, "mulh_min");
        run_op(MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 0, "mulhu_max");
        run_op(MDU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT, 0, "mulhsu");
        run_op(MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, 0, "div_-7/2");
        run_op(MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, 0, "rem_-7/2");
        run_op(MDU_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT, 0, "divu_100/7");
        run_op(MDU_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT, 0, "remu_100/7");
        run_op(MDU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,       0, "div_by0");
        run_op(MDU_REM,    32'd5,        32'd0,        32'd5,        1,       0, "rem_by0");
        run_op(MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,       0, "div_ovf");
        run_op(MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,       0, "rem_ovf");
        run_op(MDU_DIVU,   32'hDEADBEEF, 32'd0,        32'hFFFFFFFF, 1,       0, "divu_by0");
        run_op(MDU_REMU,   32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1,       0, "remu_by0");
        run_op(MDU_DIV,    32'd99,       32'hFFFFFFF6, 32'hFFFFFFF7, DIV_LAT, 10, "div_hold");

        abort_test(1'b0, "flush_calc");
        abort_test(1'b1, "reset_calc");

        // Flush together with a request in IDLE must drop the request.
        in_valid = 1'b1;
        flush = 1'b1;
        sel = MDU_DIV;
        d1 = 32'd5;
        d2 = 32'd0;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_idle_in_ready", 32'(in_ready), 32'd1);
        chk("flush_idle_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (5) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk("flush_idle_no_result", 32'(seen), 32'd0);
        $display("flush with request in IDLE: discarded=%0d", !seen);

        for (int i = 0; i < 8; i++) begin
            rs = 3'(i);
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i == 6) ra = 32'h80000000;
            run_op(rs, ra, rb, ref_model(rs, ra, rb), ref_lat(rs, ra, rb), 0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mdu_controller.md
# mdu_controller

Multi-cycle sequencer for the RV32M multiply/divide operations (SELECT 01xxx group) in the EX stage.
- Accepts one operation through a valid/ready handshake and runs an iterative shift-add multiplier or a restoring divider for 32 cycles.
- Applies sign correction and holds the result until the pipeline takes it.
- The EX stage stalls on BUSY; RISC-V special cases (divide-by-zero, signed overflow) are resolved without iterating.

## Interface
- XLEN, 32: operand/result width; iteration counter width is $clog2(XLEN)+1.
- CLK  input  1  clock, rising edge.
- RESET  input  1  reset; one clock; reset is synchronous and active-high.
- IN_VALID  input  1  operation request.
- IN_READY  output  1  high only in IDLE; transfer on IN_VALID & IN_READY at a rising edge.
- SELECT  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DATA1  input  XLEN  rs1 (multiplicand/dividend).
- DATA2  input  XLEN  rs2 (multiplier/divisor).
- FLUSH  input  1  abort current operation (branch mispredict/trap).
- OUT_VALID  output  1  RESULT valid; held until OUT_READY.
- OUT_READY  input  1  consumer accepts result.
- RESULT  output  XLEN  registered result.
- BUSY  output  1  high in CALC, FIX, DONE.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE → CALC on accept.**
  - Latch op.
  - Latch |DATA1| and |DATA2| per signedness: MULH and DIV/REM treat both operands as signed; MULHSU treats DATA1 only as signed; MUL, MULHU, DIVU and REMU treat both as unsigned.
  - Latch sign flags; load counter = XLEN.
- **IDLE → FIX on accept (special cases)**, with the result preloaded:
  - Divisor == 0: DIV/DIVU give all-ones; REM/REMU give DATA1.
  - DIV with DATA1 = 0x80000000, DATA2 = 0xFFFFFFFF: result 0x80000000. REM in the same case gives 0.
- **CALC, multiply:**
  - One shift-add step per cycle on a 2·XLEN accumulator.
  - Counter decrements each cycle; move to FIX when it reaches 0 (after 32 steps).
- **CALC, divide:**
  - One restoring step per cycle: shift remainder left by 1, bring in the next dividend bit.
  - Subtract divisor if the result is non-negative, and set the quotient bit.
  - 32 steps.
- **FIX:** one cycle; load RESULT, then go to DONE.
  - MUL: low word.
  - MULH/MULHSU: 64-bit negation when the sign flags differ, then high word.
  - MULHU: high word.
  - DIV: negate quotient when signs differ.
  - REM: remainder takes the dividend's sign.
  - Unsigned ops: no correction.
- **DONE:** OUT_VALID = 1, RESULT stable; go to IDLE on OUT_READY. No new accept until IDLE.
- **Priority:** RESET > FLUSH > normal.
  - FLUSH in any state: go to IDLE next edge, OUT_VALID = 0, no result delivered.
  - FLUSH together with IN_VALID in IDLE: request is discarded.
- **Reset values:** state IDLE, IN_READY = 1, OUT_VALID = 0, BUSY = 0, RESULT = 0, counter = 0.
- RESET mid-operation behaves the same as FLUSH.
- SELECT, DATA1 and DATA2 are ignored outside the accept edge.

## Timing
- Accept edge E0.
- Iterative path: CALC covers E1..E32, FIX at E33, OUT_VALID high after E33. Latency is 33 edges.
- Special-case and fast-mul path: FIX after E0, OUT_VALID high after E1. Latency is 1 edge.
- If OUT_READY is high in the first DONE cycle, IDLE follows at the next edge. The earliest next accept is the edge after returning to IDLE, giving a throughput of 1 op per 35 cycles.
- IN_READY and BUSY are decoded from registered state only; no combinational path from IN_VALID.
- OUT_READY affects only the DONE → IDLE transition.

## Configuration
- **MDU_FAST_MUL_EN defined:**
  - MUL/MULH/MULHSU/MULHU compute the full 2·XLEN product with a single-cycle multiplier at accept.
  - IDLE → FIX, with 1-edge latency like the special cases.
  - Divide ops remain iterative.
- **Undefined:** multiply uses the 32-cycle shift-add path; no `*` operator is synthesized.

## Structure
- **Package mdu_pkg:**
  - Op encodings MDU_MUL…MDU_REMU (3-bit).
  - State enum (IDLE, CALC, FIX, DONE).
  - XLEN default and the divide-by-zero/overflow constants.
- **Sub-module mdu_div_step:**
  - Combinational single restoring step: inputs remainder, dividend bit, divisor.
  - Outputs next remainder and quotient bit.
- The controller owns the FSM, counter, operand/accumulator registers and sign fix-up.

## Test plan
- MUL 7 × −3 (DATA1 = 7, DATA2 = 0xFFFFFFFD) → RESULT 0xFFFFFFEB; OUT_VALID 33 edges after accept, or 1 edge with MDU_FAST_MUL_EN.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5; DIV 0x80000000 / −1 → 0x80000000 and REM → 0; each with OUT_VALID 1 edge after accept.
- OUT_READY low for 10 cycles in DONE: RESULT and OUT_VALID hold and IN_READY stays 0; OUT_READY pulse → IDLE next edge.
- FLUSH at CALC cycle 15, and separately RESET at CALC cycle 15: IDLE next edge, OUT_VALID never asserted; a following DIVU 9/3 returns 3 correctly.
